// File: rtl/param_sync_fifo_pkg.sv
// Shared sizing constants, helpers and the per-cycle operation type for param_sync_fifo.
package param_sync_fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 8;

    // Accepted transfer in one cycle, packed as {write_accepted, read_accepted}.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_t;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage for param_sync_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately left unreset; only written entries are ever read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags and overflow/underflow pulses.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered 1-cycle read.
module param_sync_fifo
    import param_sync_fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en_i,
    input  logic [DATA_W-1:0]             data_i,
    output logic                          full_o,
    output logic                          almost_full_o,
    output logic                          overflow_o,
    input  logic                          rd_en_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          valid_o,
    output logic                          empty_o,
    output logic                          almost_empty_o,
    output logic                          underflow_o,
    output logic [count_width(DEPTH)-1:0] count_o
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = count_width(DEPTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow_q;
    logic              underflow_q;
    logic              wr_accept;
    logic              rd_accept;
    logic [DATA_W-1:0] rd_data;
    fifo_op_t          op;

    // Flags come straight from the registered count, so they move one cycle after the accepting edge.
    assign full_o         = (count == FULL_COUNT);
    assign empty_o        = (count == '0);
    assign almost_full_o  = (int'(count) >= AF_THRESH);
    assign almost_empty_o = (int'(count) <= AE_THRESH);
    assign count_o        = count;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign wr_accept = wr_en_i & ~full_o;
    assign rd_accept = rd_en_i & ~empty_o;
    assign op        = fifo_op_t'({wr_accept, rd_accept});

    fifo_mem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .wr_en  (wr_accept),
        .wr_addr(wr_ptr),
        .wr_data(data_i),
        .rd_addr(rd_ptr),
        .rd_data(rd_data)
    );

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (op)
                OP_WRITE: count <= count + 1'b1;
                OP_READ:  count <= count - 1'b1;
                default:  count <= count;
            endcase
            overflow_q  <= wr_en_i & full_o;
            underflow_q <= rd_en_i & empty_o;
        end
    end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
    assign data_o  = empty_o ? '0 : rd_data;
    assign valid_o = ~empty_o;
`else
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Read data is captured on the accepting edge and held until the next accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_accept;
            if (rd_accept) begin
                data_q <= rd_data;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
`endif

endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parametrised single-clock FIFO, the next generation of our 8x8 synchronous FIFO. Generalises data width and depth and adds almost-full/almost-empty thresholds, an occupancy count, sticky-free overflow/underflow pulses, a read-valid strobe and a compile-time first-word-fall-through mode. Sits between any producer/consumer pair in the same clock domain, e.g. between the UART receiver and the packet parser.

## Interface
- DATA_W, 8: data width in bits (>=1)
- DEPTH, 8: number of entries; power of two, >=2
- AF_THRESH, DEPTH-2: almost_full_o asserts when count >= AF_THRESH
- AE_THRESH, 2: almost_empty_o asserts when count <= AE_THRESH

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en_i  in  1  write request
- data_i  in  DATA_W  write data
- full_o  out  1  count == DEPTH
- almost_full_o  out  1  count >= AF_THRESH
- overflow_o  out  1  one-cycle pulse: previous-cycle write rejected
- rd_en_i  in  1  read request
- data_o  out  DATA_W  read data
- valid_o  out  1  data_o holds a valid word (see Configuration)
- empty_o  out  1  count == 0
- almost_empty_o  out  1  count <= AE_THRESH
- underflow_o  out  1  one-cycle pulse: previous-cycle read rejected
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Write accepted = wr_en_i & ~full_o; stores data_i at wr_ptr, wr_ptr += 1.
- Read accepted = rd_en_i & ~empty_o; rd_ptr += 1.
- Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0 naturally.
- Count: +1 on write-only accept, -1 on read-only accept, unchanged on both or neither.
- Simultaneous at full: read accepted, write rejected (full_o evaluated from current count), count -> DEPTH-1, overflow_o pulses.
- Simultaneous at empty: write accepted, read rejected, count -> 1, underflow_o pulses.
- All status flags decode combinationally from registered count; no other state.
- Memory array not reset; contents undefined until written.
- Reset (any time, including mid-transfer): pointers, count, data_o, valid_o, overflow_o, underflow_o -> 0; empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0 (for AF_THRESH>0). In-flight data discarded.

## Timing
- Word written at edge N is readable by a read request sampled at edge N+1 (no same-cycle write-to-read bypass when empty).
- Flags and count_o update one cycle after the accepting edge.
- overflow_o / underflow_o: registered, high for exactly the cycle after the rejected request.
- Standard mode: data_o registered on the accepting read edge; valid_o high for that following cycle only; data_o holds last value otherwise.

## Configuration
- Macro PARAM_SYNC_FIFO_FWFT_EN.
- Undefined (default): standard mode as above, 1-cycle read latency.
- Defined: first-word-fall-through. data_o = mem[rd_ptr] combinationally when empty_o=0, else 0; valid_o = ~empty_o; rd_en_i pops the displayed word at the edge. No data_o register. Flag/count/error behaviour identical.

## Structure
- Package param_sync_fifo_pkg: default DATA_W/DEPTH constants, count-width function ($clog2(DEPTH)+1), pointer-width function.
- Sub-module fifo_mem: DEPTH x DATA_W register array, one synchronous write port, one asynchronous read port; control, count and flag logic stay in param_sync_fifo.

## Test plan
- Reset, then write 0x11..0x18 (DEPTH=8) -> full_o=1 after 8th edge, count_o=8, almost_full_o from count 6; read all -> 0x11..0x18 in order, empty_o=1.
- Write while full (data 0xAA) -> overflow_o high one cycle, count stays 8, 0xAA never read.
- Read while empty -> underflow_o high one cycle, count stays 0, valid_o stays 0.
- Simultaneous wr/rd at count 3 for 20 cycles -> count_o stays 3, pointers wrap, data order preserved.
- Simultaneous wr/rd at full -> count 7, overflow_o pulse; at empty -> count 1, underflow_o pulse.
- Assert rst_n low mid-burst at count 5 -> all outputs reach reset values asynchronously; FWFT build: data_o shows 0x11 before rd_en_i after first write.
